carry_save_adder: RTL and testbench

CARRY_SAVE_ADDER -- requirements
Module: carry_save_adder

---
 rtl/carry_save_adder.sv | 101 ++++++++++
 tb/tb_carry_save_adder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/carry_save_adder.sv
// carry_save_adder: sums N unsigned W-bit operands in a single clock.
// The operands go through a row of 3:2 compressors until two vectors remain.
// One carry-propagate add then merges those two vectors, and a register
// captures the result. All internal vectors are N+2 bits wide, which is
// enough to hold the largest possible total.
module carry_save_adder #(
    parameter int N = 9,
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W*N-1:0] a,
    input  logic           in_valid,
    output logic [N:0]     sum,
    output logic           cout,
    output logic           out_valid
);

    localparam int VW = N + 2;

    // The largest possible total must fit in VW bits. Otherwise the
    // discarded top carries would corrupt the result.
    localparam logic [63:0] MAX_TOTAL = 64'(N) * ((64'd1 << W) - 64'd1);
    localparam logic [63:0] LIMIT     = 64'd1 << VW;

    if ((N < 3) || (W < 1) || (MAX_TOTAL >= LIMIT)) begin : g_bad_params
        $fatal(1, "carry_save_adder: N*(2^W-1) must be < 2^(N+2), N >= 3, W >= 1");
    end

    // Full-adder row: bitwise sum vector of three inputs.
    function automatic logic [VW-1:0] csa_sum(
        input logic [VW-1:0] x,
        input logic [VW-1:0] y,
        input logic [VW-1:0] z
    );
        return x ^ y ^ z;
    endfunction

    // Full-adder row: majority carries shifted one place left.
    // The carry out of the top bit is dropped; it cannot occur here.
    function automatic logic [VW-1:0] csa_carry(
        input logic [VW-1:0] x,
        input logic [VW-1:0] y,
        input logic [VW-1:0] z
    );
        logic [VW-1:0] maj;
        maj = (x & y) | (x & z) | (y & z);
        return {maj[VW-2:0], 1'b0};
    endfunction

    logic [VW-1:0] acc_sum_s;
    logic [VW-1:0] acc_carry_s;
    logic [VW-1:0] operand_s;
    logic [VW-1:0] row_sum_s;
    logic [VW-1:0] row_carry_s;
    logic [VW-1:0] total_s;

    logic [N:0]    sum_r;
    logic          cout_r;
    logic          out_valid_r;

    // Compress the operands pairwise into a sum/carry vector pair,
    // then resolve that pair with one carry-propagate add.
    always_comb begin
        acc_sum_s   = {{(VW-W){1'b0}}, a[0 +: W]};
        acc_carry_s = {{(VW-W){1'b0}}, a[W +: W]};
        operand_s   = {VW{1'b0}};
        row_sum_s   = {VW{1'b0}};
        row_carry_s = {VW{1'b0}};
        for (int k = 2; k < N; k++) begin
            operand_s   = {{(VW-W){1'b0}}, a[k*W +: W]};
            row_sum_s   = csa_sum(acc_sum_s, acc_carry_s, operand_s);
            row_carry_s = csa_carry(acc_sum_s, acc_carry_s, operand_s);
            acc_sum_s   = row_sum_s;
            acc_carry_s = row_carry_s;
        end
        total_s = acc_sum_s + acc_carry_s;
    end

    // Result register. Reset wins over in_valid. The result holds
    // whenever no valid operand set is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r       <= {(N+1){1'b0}};
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                {cout_r, sum_r} <= total_s;
            end else begin
                {cout_r, sum_r} <= {cout_r, sum_r};
            end
        end
    end

    assign sum       = sum_r;
    assign cout      = cout_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_carry_save_adder.sv
// Testbench for carry_save_adder.
// The main instance uses the default size (N=9, W=4). A second instance
// (N=3, W=3) exercises the case where the result carries into cout.
module tb_carry_save_adder;

    localparam int N  = 9;
    localparam int W  = 4;
    localparam int N2 = 3;
    localparam int W2 = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [W*N-1:0]  a;
    logic            in_valid;
    logic [N:0]      sum;
    logic            cout;
    logic            out_valid;

    logic [W2*N2-1:0] a2;
    logic [N2:0]      sum2;
    logic             cout2;
    logic             out_valid2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W*N-1:0] a;
        logic [N+1:0]   total;
    } vec_t;

    vec_t vecs[10];

    carry_save_adder #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .a(a), .in_valid(in_valid),
        .sum(sum), .cout(cout), .out_valid(out_valid)
    );

    carry_save_adder #(.N(N2), .W(W2)) dut_small (
        .clk(clk), .rst(rst), .a(a2), .in_valid(in_valid),
        .sum(sum2), .cout(cout2), .out_valid(out_valid2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: plain nibble-by-nibble sum of the operands.
    function automatic logic [N+1:0] ref_total(input logic [W*N-1:0] v);
        logic [N+1:0] t;
        t = '0;
        for (int k = 0; k < N; k++) t = t + (N+2)'(v[k*W +: W]);
        return t;
    endfunction

    initial begin
        logic [W*N-1:0] lfsr;

        vecs[0] = '{36'h000000000, 11'd0};
        vecs[1] = '{36'hFFFFFFFFF, 11'd135};
        vecs[2] = '{36'h00000000A, 11'd10};
        vecs[3] = '{36'h0000000AA, 11'd20};
        vecs[4] = '{36'h000000C64, 11'd22};
        vecs[5] = '{36'h123456789, 11'd45};
        vecs[6] = '{36'h800000000, 11'd8};
        vecs[7] = '{36'hF0F0F0F0F, 11'd75};
        vecs[8] = '{36'h0F0F0F0F0, 11'd60};
        vecs[9] = '{36'h111111111, 11'd9};

        // Reset for two cycles with a live operand set that must be dropped.
        rst = 1'b1; in_valid = 1'b1; a = '1; a2 = '1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_total", {cout, sum}, 64'd0);
            check("reset_valid", out_valid, 64'd0);
        end

        // First cycle after reset accepts an operand set.
        rst = 1'b0; a = '0; a2 = '0; in_valid = 1'b1;
        @(negedge clk);
        check("post_reset_total", {cout, sum}, 64'd0);
        check("post_reset_valid", out_valid, 64'd1);

        // Table of directed vectors, back to back.
        for (int i = 0; i < 10; i++) begin
            a = vecs[i].a;
            @(negedge clk);
            check($sformatf("vec%0d_total", i), {cout, sum}, 64'(vecs[i].total));
            check($sformatf("vec%0d_valid", i), out_valid, 64'd1);
        end
        check("all_ones_cout", cout, 64'd0);

        // Small instance: 7+7+7 = 21 -> cout=1, sum=5; then 3+2+1 = 6.
        a2 = 9'h1FF;
        @(negedge clk);
        check("small_cout", cout2, 64'd1);
        check("small_sum", sum2, 64'd5);
        a2 = {3'd1, 3'd2, 3'd3};
        @(negedge clk);
        check("small_total", {cout2, sum2}, 64'd6);

        // Reset mid-stream with in_valid high.
        a = '1;
        @(negedge clk);
        check("pre_midreset_total", {cout, sum}, 64'd135);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_total", {cout, sum}, 64'd0);
        check("midreset_valid", out_valid, 64'd0);
        check("midreset_small", {cout2, sum2}, 64'd0);

        // in_valid toggles 1,0,1: out_valid follows one cycle later
        // and the result holds through the gap.
        rst = 1'b0; a = 36'h00000000A; in_valid = 1'b1;
        @(negedge clk);
        check("toggle1_total", {cout, sum}, 64'd10);
        check("toggle1_valid", out_valid, 64'd1);
        a = '1; in_valid = 1'b0;
        @(negedge clk);
        check("gap_hold_total", {cout, sum}, 64'd10);
        check("gap_valid", out_valid, 64'd0);
        a = 36'h0000000AA; in_valid = 1'b1;
        @(negedge clk);
        check("toggle2_total", {cout, sum}, 64'd20);
        check("toggle2_valid", out_valid, 64'd1);

        // Shifting pattern stream at full throughput.
        lfsr = 36'd5677990231;
        for (int i = 0; i < 10000; i++) begin
            a = lfsr;
            @(negedge clk);
            check("stream_total", {cout, sum}, 64'(ref_total(lfsr)));
            lfsr = {lfsr[W*N-2:0], lfsr[W*N-1] ^ lfsr[W*N-2]};
        end
        check("stream_valid", out_valid, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
